// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline stage register with valid/ready handshake, stall,
// flush/squash and bubble-safe control gating. Also produces the
// registered branch-taken decision (pc_src) for the PC mux.
// Optional statistics counters: define EX_MEM_PIPE_STATS_EN to add
// stall_cnt / squash_cnt outputs.
module ex_mem_pipe_reg #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int WB_W   = 2,
  parameter int M_W    = 3,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [M_W-1:0]    m_in,
  input  logic [DATA_W-1:0] adder_out_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] write_data_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              zero_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_out,
  output logic [M_W-1:0]    m_out,
  output logic [DATA_W-1:0] adder_out_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] write_data_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              zero_out,
  output logic              pc_src_out
`ifdef EX_MEM_PIPE_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] squash_cnt
`endif
);

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    logic [STAT_W-1:0] one;
    one = {{(STAT_W-1){1'b0}}, 1'b1};
    return (v == {STAT_W{1'b1}}) ? v : v + one;
  endfunction

  logic              vld_p1;
  logic [WB_W-1:0]   wb_p1;
  logic [M_W-1:0]    m_p1;
  logic              pc_src_p1;
  logic [DATA_W-1:0] adder_p1;
  logic [DATA_W-1:0] alu_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [RD_W-1:0]   rd_p1;
  logic              zero_p1;

  logic load;
  logic drain;

  // Stage is free when empty or when its current bundle leaves this cycle.
  assign in_ready = !vld_p1 || out_ready;
  assign load     = in_valid && in_ready && !flush;
  assign drain    = vld_p1 && out_ready && !load;

  // ---- EX -> MEM stage boundary ----
  // Control bundle: cleared on bubbles so an empty stage never writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      wb_p1     <= '0;
      m_p1      <= '0;
      pc_src_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      wb_p1     <= '0;
      m_p1      <= '0;
      pc_src_p1 <= 1'b0;
    end else if (load) begin
      vld_p1    <= 1'b1;
      wb_p1     <= wb_in;
      m_p1      <= m_in;
      pc_src_p1 <= m_in[0] & zero_in;
    end else if (drain) begin
      vld_p1    <= 1'b0;
      wb_p1     <= '0;
      m_p1      <= '0;
      pc_src_p1 <= 1'b0;
    end
  end

  // Data payload: captured on load only, otherwise holds (also across flush).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adder_p1 <= '0;
      alu_p1   <= '0;
      wdata_p1 <= '0;
      rd_p1    <= '0;
      zero_p1  <= 1'b0;
    end else if (load) begin
      adder_p1 <= adder_out_in;
      alu_p1   <= alu_result_in;
      wdata_p1 <= write_data_in;
      rd_p1    <= rd_in;
      zero_p1  <= zero_in;
    end
  end

  assign out_valid      = vld_p1;
  assign wb_out         = wb_p1;
  assign m_out          = m_p1;
  assign pc_src_out     = pc_src_p1;
  assign adder_out_out  = adder_p1;
  assign alu_result_out = alu_p1;
  assign write_data_out = wdata_p1;
  assign rd_out         = rd_p1;
  assign zero_out       = zero_p1;

`ifdef EX_MEM_PIPE_STATS_EN
  logic [STAT_W-1:0] stall_cnt_p1;
  logic [STAT_W-1:0] squash_cnt_p1;

  // Stall and squash event counters, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_p1  <= '0;
      squash_cnt_p1 <= '0;
    end else begin
      if (vld_p1 && !out_ready && !flush)
        stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      if (flush && (vld_p1 || in_valid))
        squash_cnt_p1 <= sat_inc(squash_cnt_p1);
    end
  end

  assign stall_cnt  = stall_cnt_p1;
  assign squash_cnt = squash_cnt_p1;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: directed scenarios plus a
// randomized run against a bundle-level reference model.
module tb_ex_mem_pipe_reg;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready;
  logic          in_ready, out_valid, zero_in, zero_out, pc_src_out;
  logic [1:0]    wb_in, wb_out;
  logic [2:0]    m_in, m_out;
  logic [DW-1:0] adder_in, alu_in, wd_in, adder_out, alu_out, wd_out;
  logic [4:0]    rd_in, rd_out;

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(.DATA_W(DW), .RD_W(5), .WB_W(2), .M_W(3), .STAT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .wb_in(wb_in), .m_in(m_in), .adder_out_in(adder_in), .alu_result_in(alu_in),
    .write_data_in(wd_in), .rd_in(rd_in), .zero_in(zero_in), .out_valid(out_valid),
    .out_ready(out_ready), .wb_out(wb_out), .m_out(m_out), .adder_out_out(adder_out),
    .alu_result_out(alu_out), .write_data_out(wd_out), .rd_out(rd_out),
    .zero_out(zero_out), .pc_src_out(pc_src_out)
`ifdef EX_MEM_PIPE_STATS_EN
    , .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
`endif
  );

`ifdef EX_MEM_PIPE_STATS_EN
  logic [31:0]   stall_cnt, squash_cnt;
  logic [1:0]    stall_cnt_s, squash_cnt_s;
  logic          s_in_ready, s_out_valid, s_zero, s_pc;
  logic [1:0]    s_wb;
  logic [2:0]    s_m;
  logic [DW-1:0] s_adder, s_alu, s_wd;
  logic [4:0]    s_rd;

  ex_mem_pipe_reg #(.DATA_W(DW), .RD_W(5), .WB_W(2), .M_W(3), .STAT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .wb_in(wb_in), .m_in(m_in), .adder_out_in(adder_in), .alu_result_in(alu_in),
    .write_data_in(wd_in), .rd_in(rd_in), .zero_in(zero_in), .out_valid(s_out_valid),
    .out_ready(out_ready), .wb_out(s_wb), .m_out(s_m), .adder_out_out(s_adder),
    .alu_result_out(s_alu), .write_data_out(s_wd), .rd_out(s_rd),
    .zero_out(s_zero), .pc_src_out(s_pc), .stall_cnt(stall_cnt_s), .squash_cnt(squash_cnt_s)
  );
`endif

  // All observable registered outputs packed for whole-bundle comparison.
  logic [204:0] dut_vec;
  assign dut_vec = {out_valid, wb_out, m_out, adder_out, alu_out, wd_out, rd_out, zero_out, pc_src_out};

  // Reference model: the stage holds at most one bundle; an empty stage
  // shows zero control regardless of what payload it last held.
  typedef struct packed {
    logic [1:0]    wb;
    logic [2:0]    m;
    logic [DW-1:0] adder, alu, wd;
    logic [4:0]    rd;
    logic          zero;
  } bundle_t;

  bundle_t stage;
  bit      full;
  int      passed = 0;
  int      total  = 0;

  function automatic logic [204:0] exp_vec();
    logic [1:0] wb_v;
    logic [2:0] m_v;
    wb_v = full ? stage.wb : 2'b0;
    m_v  = full ? stage.m  : 3'b0;
    return {full, wb_v, m_v, stage.adder, stage.alu, stage.wd, stage.rd, stage.zero,
            full & stage.m[0] & stage.zero};
  endfunction

  task automatic model_step();
    bundle_t cur;
    cur = '{wb: wb_in, m: m_in, adder: adder_in, alu: alu_in, wd: wd_in, rd: rd_in, zero: zero_in};
    if (!rst_n) begin
      stage = '0;
      full  = 0;
    end else if (flush) begin
      full = 0;
    end else if (in_valid && (!full || out_ready)) begin
      stage = cur;
      full  = 1;
    end else if (out_ready) begin
      full = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    wb_in    = 2'($urandom);
    m_in     = 3'($urandom);
    adder_in = {$urandom, $urandom};
    alu_in   = {$urandom, $urandom};
    wd_in    = {$urandom, $urandom};
    rd_in    = 5'($urandom);
    zero_in  = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 0; flush = 0; in_valid = 1; out_ready = 1'($urandom);
    rand_inputs();
    tick();
    total++; if (dut_vec !== 205'd0) $display("FAIL reset_outputs got %h exp 0", dut_vec); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passed++;
    rst_n = 1; in_valid = 0;
  endtask

  task automatic test_load();
    rand_inputs();
    in_valid = 1; out_ready = 1; m_in = 3'b001; zero_in = 1;
    alu_in = 64'h1234; rd_in = 5'd7;
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) $display("FAIL load_valid got %b exp 1", out_valid); else passed++;
    total++; if (pc_src_out !== 1'b1) $display("FAIL load_pc_src got %b exp 1", pc_src_out); else passed++;
    total++; if (alu_out !== 64'h1234) $display("FAIL load_alu got %h exp 1234", alu_out); else passed++;
    total++; if (rd_out !== 5'd7) $display("FAIL load_rd got %0d exp 7", rd_out); else passed++;
    total++; if (dut_vec !== exp_vec()) $display("FAIL load_bundle got %h exp %h", dut_vec, exp_vec()); else passed++;
  endtask

  task automatic test_stall();
    rand_inputs();
    in_valid = 1; out_ready = 1; alu_in = 64'hA;
    tick();
    out_ready = 0; alu_in = 64'hB;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got %b exp 0", i, in_ready); else passed++;
      tick();
      total++; if (alu_out !== 64'hA || out_valid !== 1'b1)
        $display("FAIL stall_hold[%0d] got alu=%h v=%b exp alu=a v=1", i, alu_out, out_valid);
      else passed++;
    end
    out_ready = 1;
    tick();
    in_valid = 0;
    total++; if (alu_out !== 64'hB || out_valid !== 1'b1)
      $display("FAIL stall_release got alu=%h v=%b exp alu=b v=1", alu_out, out_valid);
    else passed++;
  endtask

  task automatic test_flush();
    logic [DW-1:0] old_alu;
    rand_inputs();
    in_valid = 1; out_ready = 1; m_in = 3'b100; wb_in = 2'b11;
    old_alu = alu_in;
    tick();
    total++; if (m_out !== 3'b100 || out_valid !== 1'b1)
      $display("FAIL flush_pre got m=%b v=%b exp m=100 v=1", m_out, out_valid);
    else passed++;
    rand_inputs();
    flush = 1; in_valid = 1; out_ready = 1; m_in = 3'b111; zero_in = 1;
    alu_in = ~old_alu;
    tick();
    flush = 0; in_valid = 0;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", out_valid); else passed++;
    total++; if (m_out !== 3'b0 || wb_out !== 2'b0)
      $display("FAIL flush_ctrl got m=%b wb=%b exp 0", m_out, wb_out);
    else passed++;
    total++; if (pc_src_out !== 1'b0) $display("FAIL flush_pc_src got %b exp 0", pc_src_out); else passed++;
    total++; if (alu_out !== old_alu) $display("FAIL flush_data_hold got %h exp %h", alu_out, old_alu); else passed++;
    total++; if (dut_vec !== exp_vec()) $display("FAIL flush_bundle got %h exp %h", dut_vec, exp_vec()); else passed++;
  endtask

  task automatic test_back_to_back();
    in_valid = 1; out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      rand_inputs();
      alu_in = 64'(i);
      tick();
      total++; if (alu_out !== 64'(i) || out_valid !== 1'b1)
        $display("FAIL b2b[%0d] got alu=%h v=%b exp alu=%h v=1", i, alu_out, out_valid, 64'(i));
      else passed++;
      total++; if (dut_vec !== exp_vec()) $display("FAIL b2b_bundle[%0d] got %h exp %h", i, dut_vec, exp_vec()); else passed++;
    end
    in_valid = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      rst_n     = ($urandom_range(0, 49) != 0);
      flush     = ($urandom_range(0, 7) == 0);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      total++; if (in_ready !== (!full || out_ready))
        $display("FAIL rand_in_ready[%0d] got %b exp %b", i, in_ready, (!full || out_ready));
      else passed++;
      tick();
      total++; if (dut_vec !== exp_vec()) $display("FAIL rand_bundle[%0d] got %h exp %h", i, dut_vec, exp_vec()); else passed++;
    end
    rst_n = 1; flush = 0; in_valid = 0; out_ready = 1;
    tick();
  endtask

`ifdef EX_MEM_PIPE_STATS_EN
  task automatic test_stats();
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    tick();
    rst_n = 1;
    total++; if (stall_cnt !== 32'd0 || squash_cnt !== 32'd0)
      $display("FAIL stats_reset got %0d/%0d exp 0/0", stall_cnt, squash_cnt);
    else passed++;
    rand_inputs();
    in_valid = 1;
    tick();
    in_valid = 0; out_ready = 0;
    repeat (5) tick();
    flush = 1; in_valid = 1;
    repeat (2) tick();
    flush = 0; in_valid = 0; out_ready = 1;
    total++; if (stall_cnt !== 32'd5) $display("FAIL stats_stall got %0d exp 5", stall_cnt); else passed++;
    total++; if (squash_cnt !== 32'd2) $display("FAIL stats_squash got %0d exp 2", squash_cnt); else passed++;
    total++; if (stall_cnt_s !== 2'd3) $display("FAIL stats_stall_sat got %0d exp 3", stall_cnt_s); else passed++;
    total++; if (squash_cnt_s !== 2'd2) $display("FAIL stats_squash_small got %0d exp 2", squash_cnt_s); else passed++;
  endtask
`endif

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    stage = '0; full = 0;
    rand_inputs();
    @(negedge clk);
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_back_to_back();
    test_random();
`ifdef EX_MEM_PIPE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
Parametrised EX/MEM pipeline stage register for the 64-bit single-issue datapath.
- Sits between ALU/branch-adder outputs and the data-memory stage.
- Adds a valid/ready handshake, back-pressure (stall), flush/squash and bubble-safe control gating.
- Latches the ALU Zero flag and produces a registered branch-taken (PCSrc) decision for the PC mux.

Parameters:
DATA_W, 64, width of branch target, ALU result and store data
RD_W, 5, destination register index width
WB_W, 2, WB control bundle width; bit0 RegWrite, bit1 MemtoReg
M_W, 3, M control bundle width; bit0 Branch, bit1 MemRead, bit2 MemWrite
STAT_W, 32, statistics counter width (optional feature only)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
flush  in  1  squash stage contents and any bundle offered this cycle
in_valid  in  1  EX presents a bundle
in_ready  out  1  stage can accept; = !out_valid || out_ready (combinational)
wb_in  in  WB_W  WB control
m_in  in  M_W  M control
adder_out_in  in  DATA_W  branch target
alu_result_in  in  DATA_W  ALU result / memory address
write_data_in  in  DATA_W  store data
rd_in  in  RD_W  destination register
zero_in  in  1  ALU Zero flag
out_valid  out  1  MEM-side bundle valid
out_ready  in  1  MEM stage consumes bundle
wb_out  out  WB_W  registered WB control
m_out  out  M_W  registered M control
adder_out_out  out  DATA_W  registered branch target
alu_result_out  out  DATA_W  registered ALU result
write_data_out  out  DATA_W  registered store data
rd_out  out  RD_W  registered rd
zero_out  out  1  registered Zero
pc_src_out  out  1  registered m[0] & zero, valid-qualified

Behaviour:
- Reset (rst_n=0 at posedge): every output register cleared to 0, out_valid=0. Reset overrides flush and load.
- Latency: one cycle from accept to out_valid.
- load = in_valid && in_ready && !flush.
- Priority per posedge: reset > flush > load > drain > hold.
- flush=1:
  - out_valid <= 0; wb_out, m_out, pc_src_out <= 0.
  - Data fields (adder/alu/write_data/rd/zero) hold their values.
  - The offered bundle is discarded, even when in_ready=1.
- load: all payload fields captured; out_valid <= 1; pc_src_out <= m_in[0] & zero_in.
  - Simultaneous drain and load (out_valid && out_ready && in_valid) is a back-to-back replace with no bubble.
- drain (out_valid && out_ready && !load): out_valid <= 0; wb_out, m_out, pc_src_out <= 0; data fields hold.
- hold (out_valid && !out_ready): every output stable and bit-identical; in_ready=0; any offered bundle is left pending upstream.
- Invariant: out_valid=0 implies wb_out=0, m_out=0, pc_src_out=0, so a bubble never writes registers or memory.
- All data paths are pass-through; no arithmetic except the AND for pc_src.

Optional Feature:
Macro EX_MEM_PIPE_STATS_EN.
- Defined: adds output ports stall_cnt [STAT_W] and squash_cnt [STAT_W]; both reset to 0.
  - stall_cnt increments each cycle with out_valid && !out_ready && !flush.
  - squash_cnt increments by 1 each cycle flush=1 and (out_valid || in_valid).
  - Both saturate at all-ones.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset: rst_n=0 with in_valid=1 and arbitrary inputs -> next cycle all outputs 0, out_valid=0, in_ready=1.
- Load: in_valid=1, out_ready=1, m_in=3'b001, zero_in=1, alu_result_in=64'h1234, rd_in=5'd7 -> next cycle out_valid=1, pc_src_out=1, alu_result_out=64'h1234, rd_out=7.
- Stall: load 64'hA, hold out_ready=0 for 3 cycles while offering 64'hB -> in_ready=0, alu_result_out stays 64'hA; raise out_ready -> next cycle shows 64'hB.
- Flush: out_valid=1 with m_out=3'b100, assert flush with in_valid=1 -> next cycle out_valid=0, m_out=0, wb_out=0, pc_src_out=0, offered bundle not captured.
- Back-to-back: in_valid=out_ready=1 for 4 cycles with alu 1,2,3,4 -> outputs 1,2,3,4 on consecutive cycles, out_valid never drops.
- Stats (EX_MEM_PIPE_STATS_EN): 5 stall cycles then 2 flush cycles with in_valid=1 -> stall_cnt=5, squash_cnt=2; with STAT_W=2 and 5 stall cycles -> stall_cnt saturates at 3.
